// File: rtl/dcache_assoc.sv
// Set-associative write-back/write-allocate data cache with tree-PLRU replacement and halt flush.
// Hits complete in the cycle of the request; a miss costs its WB/LD beats plus one cycle.
// Stalls on dwait during every memory beat. Optional hit counter store: DCACHE_HITCNT_EN.
module dcache_assoc #(
    parameter int          SETS      = 8,
    parameter int          WAYS      = 2,
    parameter int          BLK_WORDS = 2,
    parameter logic [31:0] CNT_ADDR  = 32'h3100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int OFFW = $clog2(BLK_WORDS);
    localparam int IXW  = $clog2(SETS);
    localparam int WYW  = $clog2(WAYS);
    localparam int BW   = (OFFW > 0) ? OFFW : 1;
    localparam int WW   = (WYW > 0) ? WYW : 1;
    localparam int TW   = 30 - OFFW - IXW;
    localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1;

`ifdef DCACHE_HITCNT_EN
    typedef enum logic [2:0] {S_IDLE, S_WB, S_LD, S_FLUSH, S_HALT, S_CNT} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_WB, S_LD, S_FLUSH, S_HALT} state_e;
`endif

    state_e state_q, state_d;

    logic          valid_q [SETS][WAYS];
    logic          valid_d [SETS][WAYS];
    logic          dirty_q [SETS][WAYS];
    logic          dirty_d [SETS][WAYS];
    logic [TW-1:0] tag_q   [SETS][WAYS];
    logic [TW-1:0] tag_d   [SETS][WAYS];
    logic [31:0]   data_q  [SETS][WAYS][BLK_WORDS];
    logic [31:0]   data_d  [SETS][WAYS][BLK_WORDS];
    logic [PW-1:0] plru_q  [SETS];
    logic [PW-1:0] plru_d  [SETS];

    logic [BW-1:0]  beat_q, beat_d;
    logic [WW-1:0]  vway_q, vway_d;
    logic [IXW-1:0] fset_q, fset_d;
    logic [WW-1:0]  fway_q, fway_d;
`ifdef DCACHE_HITCNT_EN
    logic [31:0]    hitcnt_q, hitcnt_d;
`endif

    logic [31:0]    wa;
    logic [BW-1:0]  req_off;
    logic [IXW-1:0] req_idx;
    logic [TW-1:0]  req_tag;
    logic           req, wr, hit, inv_found, last_beat, fl_dirty, fl_adv;
    logic [WW-1:0]  hit_way, inv_way, victim;

    // Tree PLRU: node bit 1 means the victim lies in the right subtree.
    function automatic logic [WW-1:0] plru_victim(input logic [PW-1:0] p);
        int            node;
        logic [WW-1:0] w;
        logic [PW-1:0] s;
        node = 0;
        w    = '0;
        for (int l = 0; l < WYW; l++) begin
            s    = p >> node;
            w    = (w << 1) | WW'(s[0]);
            node = 2 * node + 1 + int'(s[0]);
        end
        return w;
    endfunction

    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] p, input logic [WW-1:0] way);
        int            node;
        logic [PW-1:0] r;
        logic [WW-1:0] s;
        node = 0;
        r    = p;
        for (int l = WYW - 1; l >= 0; l--) begin
            s    = way >> l;
            r    = s[0] ? (r & ~(PW'(1) << node)) : (r | (PW'(1) << node));
            node = 2 * node + 1 + int'(s[0]);
        end
        return r;
    endfunction

    function automatic logic [31:0] mk_addr(input logic [TW-1:0] t, input logic [IXW-1:0] i,
                                            input logic [BW-1:0] k);
        logic [31:0] a;
        a = 32'(t);
        a = (a << IXW) | 32'(i);
        a = (a << OFFW) | (32'(k) & 32'(BLK_WORDS - 1));
        return a << 2;
    endfunction

    assign wa        = dmemaddr >> 2;
    assign req_off   = BW'(wa & 32'(BLK_WORDS - 1));
    assign req_idx   = IXW'((wa >> OFFW) & 32'(SETS - 1));
    assign req_tag   = TW'(wa >> (OFFW + IXW));
    assign req       = dmemREN | dmemWEN;
    assign wr        = dmemWEN & ~dmemREN;
    assign last_beat = (beat_q == BW'(BLK_WORDS - 1));
    assign fl_dirty  = valid_q[fset_q][fway_q] & dirty_q[fset_q][fway_q];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Invalid ways are filled lowest-first before PLRU is consulted.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!inv_found && !valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
        victim = inv_found ? inv_way : plru_victim(plru_q[req_idx]);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        vway_d  = vway_q;
        fset_d  = fset_q;
        fway_d  = fway_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        plru_d  = plru_q;
        fl_adv  = 1'b0;
`ifdef DCACHE_HITCNT_EN
        hitcnt_d = hitcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        plru_d[req_idx] = plru_touch(plru_q[req_idx], hit_way);
                        if (wr) begin
                            data_d[req_idx][hit_way][req_off] = dmemstore;
                            dirty_d[req_idx][hit_way]         = 1'b1;
                        end
`ifdef DCACHE_HITCNT_EN
                        hitcnt_d = hitcnt_q + 32'd1;
`endif
                    end else begin
                        vway_d  = victim;
                        beat_d  = '0;
                        state_d = (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) ? S_WB : S_LD;
                    end
                end else if (halt) begin
                    state_d = S_FLUSH;
                    fset_d  = '0;
                    fway_d  = '0;
                    beat_d  = '0;
                end
            end
            S_WB: begin
                if (!dwait) begin
                    beat_d = last_beat ? '0 : beat_q + BW'(1);
                    if (last_beat) begin
                        dirty_d[req_idx][vway_q] = 1'b0;
                        state_d                  = S_LD;
                    end
                end
            end
            S_LD: begin
                if (!dwait) begin
                    data_d[req_idx][vway_q][beat_q] = dload;
                    beat_d = last_beat ? '0 : beat_q + BW'(1);
                    if (last_beat) begin
                        valid_d[req_idx][vway_q] = 1'b1;
                        dirty_d[req_idx][vway_q] = 1'b0;
                        tag_d[req_idx][vway_q]   = req_tag;
                        state_d                  = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                if (fl_dirty) begin
                    if (!dwait) begin
                        beat_d = last_beat ? '0 : beat_q + BW'(1);
                        if (last_beat) begin
                            dirty_d[fset_q][fway_q] = 1'b0;
                            fl_adv                  = 1'b1;
                        end
                    end
                end else begin
                    fl_adv = 1'b1;
                end
                if (fl_adv) begin
                    if (fway_q == WW'(WAYS - 1)) begin
                        fway_d = '0;
                        if (fset_q == IXW'(SETS - 1)) begin
`ifdef DCACHE_HITCNT_EN
                            state_d = S_CNT;
`else
                            state_d = S_HALT;
`endif
                        end else begin
                            fset_d = fset_q + IXW'(1);
                        end
                    end else begin
                        fway_d = fway_q + WW'(1);
                    end
                end
            end
`ifdef DCACHE_HITCNT_EN
            S_CNT: if (!dwait) state_d = S_HALT;
`endif
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dhit     = 1'b0;
        dmemload = '0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        case (state_q)
            S_IDLE: begin
                if (req && hit) begin
                    dhit     = 1'b1;
                    dmemload = data_q[req_idx][hit_way][req_off];
                end
            end
            S_WB: begin
                dWEN   = 1'b1;
                daddr  = mk_addr(tag_q[req_idx][vway_q], req_idx, beat_q);
                dstore = data_q[req_idx][vway_q][beat_q];
            end
            S_LD: begin
                dREN  = 1'b1;
                daddr = mk_addr(req_tag, req_idx, beat_q);
            end
            S_FLUSH: begin
                if (fl_dirty) begin
                    dWEN   = 1'b1;
                    daddr  = mk_addr(tag_q[fset_q][fway_q], fset_q, beat_q);
                    dstore = data_q[fset_q][fway_q][beat_q];
                end
            end
`ifdef DCACHE_HITCNT_EN
            S_CNT: begin
                dWEN   = 1'b1;
                daddr  = CNT_ADDR;
                dstore = hitcnt_q;
            end
`endif
            S_HALT: flushed = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
            plru_q  <= '{default: '0};
            beat_q  <= '0;
            vway_q  <= '0;
            fset_q  <= '0;
            fway_q  <= '0;
`ifdef DCACHE_HITCNT_EN
            hitcnt_q <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            plru_q  <= plru_d;
            beat_q  <= beat_d;
            vway_q  <= vway_d;
            fset_q  <= fset_d;
            fway_q  <= fway_d;
`ifdef DCACHE_HITCNT_EN
            hitcnt_q <= hitcnt_d;
`endif
        end
    end

    // Tag and data contents are only meaningful under a valid bit.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboarded bench for dcache_assoc: reference memory model, bus transaction log, PLRU/flush/reset cases.
module tb_dcache_assoc;
    localparam int SETS = 8, WAYS = 2, BLK_WORDS = 2, WAITC = 2;
`ifdef DCACHE_HITCNT_EN
    localparam int CNTON = 1;
`else
    localparam int CNTON = 0;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0;
    logic [31:0] dmemaddr = '0, dmemstore = '0;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;
    logic [31:0] dload = '0;
    logic        dwait = 1'b0;

    bus_t        log_q[$], exp_log[$];
    logic [31:0] exp_q[$];
    logic [31:0] mem  [logic [31:0]];
    logic [31:0] refm [logic [31:0]];
    int n_chk = 0, n_pass = 0, n_acc = 0, wait_cyc = WAITC, wcnt = 0, lat = 0;

    dcache_assoc #(.SETS(SETS), .WAYS(WAYS), .BLK_WORDS(BLK_WORDS), .CNT_ADDR(32'h3100)) dut (
        .CLK(CLK), .RST(RST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Memory: each beat waits wait_cyc cycles, then completes at the next rising edge.
    always @(negedge CLK) begin
        if (RST || !(dREN || dWEN)) begin
            dwait = 1'b0;
            wcnt  = 0;
        end else if (wcnt < wait_cyc) begin
            dwait = 1'b1;
            wcnt++;
        end else begin
            dwait = 1'b0;
            wcnt  = 0;
            if (dWEN) begin
                mem[daddr] = dstore;
                log_q.push_back({1'b1, daddr, dstore});
            end else begin
                dload = mem_rd(daddr);
                log_q.push_back({1'b0, daddr, dload});
            end
        end
    end

    // mode 0 read, 1 write, 2 both strobes (must behave as a read)
    task automatic access(input string tag, input int mode, input logic [31:0] a, input logic [31:0] d);
        bit got;
        int cyc;
        dmemREN   = (mode != 1);
        dmemWEN   = (mode != 0);
        dmemaddr  = a;
        dmemstore = d;
        if (mode != 1) exp_q.push_back(ref_rd(a));
        else refm[a] = d;
        got = 0;
        cyc = 0;
        while (!got && cyc < 400) begin
            @(negedge CLK);
            cyc++;
            if (dhit) begin
                got = 1;
                n_acc++;
                if (mode != 1) chk(tag, dmemload, exp_q.pop_front());
            end
            @(posedge CLK);
            #1;
        end
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        if (!got) chk({tag, "_timeout"}, 32'(got), 32'd1);
        lat = cyc;
    endtask

    function automatic void ex(input logic we, input logic [31:0] a);
        exp_log.push_back({we, a, we ? ref_rd(a) : mem_rd(a)});
    endfunction

    task automatic chk_log(input string tag);
        int n;
        chk($sformatf("%s_n", tag), log_q.size(), exp_log.size());
        n = (log_q.size() < exp_log.size()) ? log_q.size() : exp_log.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d].we", tag, i), 32'(log_q[i].we), 32'(exp_log[i].we));
            chk($sformatf("%s[%0d].addr", tag, i), log_q[i].addr, exp_log[i].addr);
            chk($sformatf("%s[%0d].data", tag, i), log_q[i].data, exp_log[i].data);
        end
        log_q.delete();
        exp_log.delete();
    endtask

    task automatic wait_flush(input string tag, input int exp_cyc);
        int cyc;
        cyc  = 0;
        halt = 1'b1;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!flushed && cyc < 2000);
        chk({tag, "_flushed"}, 32'(flushed), 32'd1);
        if (exp_cyc >= 0) chk({tag, "_cycles"}, cyc, exp_cyc);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST     = 1'b1;
        halt    = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        #1;
        chk("rst_flushed", 32'(flushed), 32'd0);
        @(posedge CLK);
        #1;
        RST   = 1'b0;
        n_acc = 0;
        log_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          t, o, k;
        logic [31:0] a;
        mem[32'h40] = 32'hA;  mem[32'h44] = 32'hB;
        refm[32'h40] = 32'hA; refm[32'h44] = 32'hB;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_dhit", 32'(dhit), 32'd0);
        chk("rst_flushed0", 32'(flushed), 32'd0);
        chk("rst_dREN", 32'(dREN), 32'd0);
        chk("rst_dWEN", 32'(dWEN), 32'd0);
        chk("rst_daddr", daddr, 32'd0);
        chk("rst_dstore", dstore, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        log_q.delete();

        // cold miss: request cycle + per-beat waits + final hit cycle
        access("rd40", 0, 32'h40, 0);
        chk("rd40_lat", lat, 1 + BLK_WORDS * (WAITC + 1) + 1);
        ex(0, 32'h40); ex(0, 32'h44); chk_log("ld40");
        access("rd44", 0, 32'h44, 0);
        chk("rd44_lat", lat, 1);
        chk_log("rd44_nobus");

        // set 0: dirty 0x80 line becomes PLRU and is written back to its own address
        access("wr80", 1, 32'h80, 32'hDEAD);
        ex(0, 32'h80); ex(0, 32'h84); chk_log("ld80");
        access("rdC0", 0, 32'hC0, 0);
        ex(0, 32'hC0); ex(0, 32'hC4); chk_log("ldC0");
        access("rd100", 0, 32'h100, 0);
        ex(1, 32'h80); ex(1, 32'h84); ex(0, 32'h100); ex(0, 32'h104); chk_log("evict80");

        // set 1: A,B,A,C -> C replaces B, A stays resident
        access("A1", 0, 32'h48, 0);
        access("B1", 0, 32'h88, 0);
        log_q.delete();
        access("A2", 0, 32'h48, 0);
        chk("A2_lat", lat, 1);
        access("C1", 0, 32'hC8, 0);
        ex(0, 32'hC8); ex(0, 32'hCC); chk_log("ldC8");
        access("A3", 0, 32'h48, 0);
        chk("A3_lat", lat, 1);
        access("B2", 0, 32'h88, 0);
        chk("B2_lat", lat, 1 + BLK_WORDS * (WAITC + 1) + 1);
        ex(0, 32'h88); ex(0, 32'h8C); chk_log("ld88");

        // one dirty line (set 3, way 1) then halt
        access("rd58", 0, 32'h58, 0);
        access("wr98", 1, 32'h98, 32'h1234_5678);
        log_q.delete();
        wait_flush("flush1", 2 + (SETS * WAYS - 1) + BLK_WORDS * (WAITC + 1) + CNTON * (WAITC + 1));
        ex(1, 32'h98); ex(1, 32'h9C);
        if (CNTON != 0) exp_log.push_back({1'b1, 32'h3100, 32'(n_acc)});
        chk_log("flush1");
        dmemREN  = 1'b1;
        dmemaddr = 32'h48;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("halt_flushed", 32'(flushed), 32'd1);
            chk("halt_nohit", 32'(dhit), 32'd0);
            chk("halt_nostrobe", 32'(dREN | dWEN), 32'd0);
        end

        // reset in the middle of a line fill
        do_reset();
        dmemREN  = 1'b1;
        dmemaddr = 32'h40;
        k = 0;
        while (log_q.size() < 1 && k < 50) begin
            @(posedge CLK);
            #1;
            k++;
        end
        chk("midld_beat0", log_q.size(), 1);
        chk("midld_dREN_on", 32'(dREN), 32'd1);
        RST = 1'b1;
        #1;
        chk("midld_dREN_off", 32'(dREN), 32'd0);
        dmemREN = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        log_q.delete();
        exp_q.delete();
        access("rd40b", 0, 32'h40, 0);
        chk("rd40b_lat", lat, 1 + BLK_WORDS * (WAITC + 1) + 1);
        ex(0, 32'h40); ex(0, 32'h44); chk_log("reload40");
        access("both44", 2, 32'h44, 32'hBAD0_BAD0);
        chk("both44_lat", lat, 1);
        access("rd44b", 0, 32'h44, 0);

        // clean flush: one cycle per line, no write beats
        wait_cyc = 0;
        log_q.delete();
        wait_flush("flush2", 2 + SETS * WAYS + CNTON);
        if (CNTON != 0) exp_log.push_back({1'b1, 32'h3100, 32'(n_acc)});
        chk_log("flush2");

        // random traffic in set 2, flush, reset, then read everything back from memory
        do_reset();
        for (int i = 0; i < 40; i++) begin
            t = $urandom_range(1, 4);
            o = $urandom_range(0, 1);
            a = 32'((t << 6) | 32'h10 | (o << 2));
            wait_cyc = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) access("rnd_wr", 1, a, $urandom);
            else access("rnd_rd", 0, a, 0);
        end
        wait_cyc = 1;
        wait_flush("flush3", -1);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a = 32'(((i / 2 + 1) << 6) | 32'h10 | ((i % 2) << 2));
            access($sformatf("readback_%0h", a), 0, a, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
